// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (port 0)
// and the UART loader (port 1); every output is registered.
module data_mem_arbiter #(
    parameter int ADDRESS_BITS = 11,
    parameter int DATA_BITS    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req0,
    input  logic                    i_req1,
    input  logic                    i_we0,
    input  logic                    i_we1,
    input  logic [ADDRESS_BITS-1:0] i_addr0,
    input  logic [ADDRESS_BITS-1:0] i_addr1,
    input  logic [DATA_BITS-1:0]    i_wdata0,
    input  logic [DATA_BITS-1:0]    i_wdata1,
    output logic                    o_gnt0,
    output logic                    o_gnt1,
    output logic                    o_rvalid0,
    output logic                    o_rvalid1,
    output logic [DATA_BITS-1:0]    o_rdata,
    output logic                    o_busy,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic [ADDRESS_BITS-1:0] o_mem_address,
    output logic [DATA_BITS-1:0]    o_mem_data,
    input  logic [DATA_BITS-1:0]    i_mem_data
);

    // state | meaning
    // IDLE  | sample requests, pick a winner
    // ISSUE | strobe memory, grant the winner
    // WAIT  | memory read latency, capture i_mem_data at the closing edge
    // RESP  | rvalid to the winner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state, state_next;
    logic                    last_gnt;
    logic                    lat_id;
    logic                    lat_we;
    logic                    take;
    logic                    win;
    logic                    win_we;
    logic [ADDRESS_BITS-1:0] win_addr;
    logic [DATA_BITS-1:0]    win_wdata;

    always_comb begin
        state_next = state;
        take       = 1'b0;
        win        = (i_req0 && i_req1) ? ~last_gnt : i_req1;
        win_we     = win ? i_we1 : i_we0;
        win_addr   = win ? i_addr1 : i_addr0;
        win_wdata  = win ? i_wdata1 : i_wdata0;
        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    take       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = lat_we ? IDLE : WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output flops are loaded from the next-state decode so strobes line up with ISSUE/RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_gnt      <= 1'b1;
            lat_id        <= 1'b0;
            lat_we        <= 1'b0;
            o_gnt0        <= 1'b0;
            o_gnt1        <= 1'b0;
            o_rvalid0     <= 1'b0;
            o_rvalid1     <= 1'b0;
            o_rdata       <= '0;
            o_busy        <= 1'b0;
            o_mem_read    <= 1'b0;
            o_mem_write   <= 1'b0;
            o_mem_address <= '0;
            o_mem_data    <= '0;
        end else begin
            state       <= state_next;
            o_busy      <= (state_next != IDLE);
            o_gnt0      <= 1'b0;
            o_gnt1      <= 1'b0;
            o_rvalid0   <= 1'b0;
            o_rvalid1   <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            if (take) begin
                lat_id        <= win;
                lat_we        <= win_we;
                last_gnt      <= win;
                o_gnt0        <= ~win;
                o_gnt1        <= win;
                o_mem_write   <= win_we;
                o_mem_read    <= ~win_we;
                o_mem_address <= win_addr;
                o_mem_data    <= win_wdata;
            end
            if (state == WAIT) begin
                o_rdata   <= i_mem_data;
                o_rvalid0 <= ~lat_id;
                o_rvalid1 <= lat_id;
            end
        end
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port DataMemory between two requesters: port 0 (BIP CPU) and port 1 (UART debug/loader unit that loads and dumps data memory).
- Sits between the requesters and DataMemory; it is the only block that drives DataMemory's read, write, i_address and i_data.
- Arbitrates round-robin, sequences each access with a small FSM, and returns read data with a valid pulse to the winning port.

Parameters:
- ADDRESS_BITS, 11, width of the data memory address.
- DATA_BITS, 16, width of the data memory word.

Ports:
- clk  in  1  system clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req0, i_req1  in  1  access request from port 0 / port 1.
- i_we0, i_we1  in  1  1 = write, 0 = read.
- i_addr0, i_addr1  in  ADDRESS_BITS  access address.
- i_wdata0, i_wdata1  in  DATA_BITS  write data.
- o_gnt0, o_gnt1  out  1  one-cycle pulse: this port's access is being issued to memory this cycle.
- o_rvalid0, o_rvalid1  out  1  one-cycle pulse: o_rdata holds this port's read result.
- o_rdata  out  DATA_BITS  read data, shared by both ports.
- o_busy  out  1  FSM is not in IDLE.
- o_mem_read  out  1  DataMemory read strobe.
- o_mem_write  out  1  DataMemory write strobe.
- o_mem_address  out  ADDRESS_BITS  DataMemory address.
- o_mem_data  out  DATA_BITS  DataMemory write data.
- i_mem_data  in  DATA_BITS  DataMemory o_data. It is registered inside DataMemory and is valid the cycle after o_mem_read.

Behaviour:
- Every output is driven from flops. There is no combinational path from any i_req/i_we/i_addr/i_wdata input to any output.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - All strobes, o_gnt*, o_rvalid* and o_busy are 0.
  - Requests are sampled only on rising edges taken in IDLE.
  - If any request is high: pick the winner, latch its we/addr/wdata and port id, go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - o_mem_write = latched we; o_mem_read = ~latched we.
  - o_mem_address / o_mem_data carry the latched values.
  - o_gnt[id] = 1.
  - Next state: IDLE for a write, WAIT for a read.
- WAIT (1 cycle):
  - Strobes are 0.
  - At the closing edge, o_rdata <= i_mem_data; go to RESP.
- RESP (1 cycle): o_rvalid[id] = 1 and o_rdata is valid; next state IDLE.
- o_rdata holds its last captured value until the next read's capture. It is not cleared between reads.
- Timing, with a request sampled at edge E:
  - gnt and mem strobe are high in cycle E+1.
  - For a read, rvalid is high in cycle E+3.
  - Throughput: one write per 2 cycles, one read per 4 cycles.
- Requester rule:
  - Hold req/we/addr/wdata stable until the gnt cycle.
  - Still asserting req at the IDLE edge after a transaction starts a new transaction. A port wanting one access must drop req in its gnt cycle (write) or by its rvalid cycle (read).
  - A request that is high in ISSUE/WAIT/RESP is ignored until the FSM returns to IDLE.
- Round-robin:
  - last_gnt register, reset value 1.
  - Only one port requesting: that port wins.
  - Both requesting: the port ≠ last_gnt wins; last_gnt is updated on entry to ISSUE.
  - Two continuously requesting ports therefore alternate 0,1,0,1…
- Invariants:
  - At most one of o_gnt0/o_gnt1 is high; at most one of o_rvalid0/o_rvalid1 is high.
  - o_mem_read and o_mem_write are never both high.
  - gnt and rvalid are never high in the same cycle.
- Reset:
  - When rst is high at an edge, the next cycle has state IDLE, all outputs 0 (o_rdata = 0, address/data = 0) and last_gnt = 1.
  - An in-flight transaction is dropped with no gnt/rvalid for it, and no memory strobe appears in the cycle after reset.
- Address and data pass through unmodified at full width. No wrap or arithmetic is applied.

Test Plan:
- Reset: assert rst for 2 cycles during a read in WAIT -> next cycle all outputs 0, state IDLE, no o_rvalid for the dropped read; first tie afterwards grants port 0.
- Single write then read:
  - port 0 write addr 5, data 8 -> o_gnt0, o_mem_write=1, o_mem_address=5, o_mem_data=8, all in the cycle after sampling.
  - then port 0 read addr 5 -> o_rvalid0 with o_rdata=8 three cycles after sampling.
- Tie: both ports request a read at the same edge (p0 addr 1, p1 addr 2, memory preloaded 0x11/0x22) -> port 0 served first (rdata 0x11, rvalid0), then port 1 (rdata 0x22, rvalid1); never both gnt.
- Fairness: both ports hold req with writes for 8 transactions -> grants alternate 0,1,0,1…; o_gnt pulses exactly 2 cycles apart.
- Back-to-back and late requests:
  - port 1 holds req through its gnt with two different addresses -> two distinct writes.
  - port 0 raising req while the FSM is in WAIT is not granted before RESP completes.
- Invariant check over 1000 cycles of random req/we/addr from both ports with a reference memory model:
  - read data always matches the model;
  - the one-hot and strobe-exclusion invariants always hold.
